// File: rtl/main_control_fsm.sv
// -----------------------------------------------------------------------------
// main_control_fsm
//
// Multicycle main control unit for the MIPS datapath. A Moore state machine
// that walks each instruction through fetch, decode, execute, memory and
// write-back. It drives the datapath mux selects and write enables and
// produces the 3-bit ALUop consumed by the ALU control decoder. Every
// memory-access state (FETCH, MEM_RD, MEM_WR) waits on mem_ready.
//
// Ports
//   clk          in   1  clock, all state changes on the rising edge
//   rst          in   1  synchronous, active-high reset
//   opcode       in   6  IR[31:26], only looked at in DECODE
//   mem_ready    in   1  memory completes the current access this cycle
//   PCWrite      out  1  unconditional PC write
//   PCWriteCond  out  1  PC write qualified by ALU zero (beq)
//   IorD         out  1  memory address select: 0 PC, 1 ALUOut
//   MemRead      out  1  memory read strobe
//   MemWrite     out  1  memory write strobe
//   IRWrite      out  1  instruction register load
//   MemtoReg     out  1  register write data: 0 ALUOut, 1 MDR
//   RegDst       out  1  destination register: 0 rt, 1 rd
//   RegWrite     out  1  register file write enable
//   ALUSrcA      out  1  ALU A: 0 PC, 1 regA
//   ALUSrcB      out  2  ALU B: 00 regB, 01 const 4, 10 sext imm, 11 imm<<2
//   PCSource     out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   ALUop        out  3  000 R-type, 001 sub, 010 slt, 011 add
//   state_out    out  4  current state code (debug)
//   illegal_op   out  1  high for the DECODE cycle of an unknown opcode
// -----------------------------------------------------------------------------
module main_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUop,
  output logic [3:0] state_out,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_SLTI  = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000110;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  state_t     w_out_state;
  logic [5:0] r_op_q;

  // State register and decoded-opcode latch; op_q is captured in DECODE so
  // later opcode changes cannot steer the remaining states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_op_q  <= 6'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_op_q <= opcode;
      end else begin
        r_op_q <= r_op_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: w_next_state = S_R_EXEC;
          OP_LW:    w_next_state = S_MEM_ADDR;
          OP_SW:    w_next_state = S_MEM_ADDR;
          OP_ADDI:  w_next_state = S_I_EXEC;
          OP_SLTI:  w_next_state = S_I_EXEC;
          OP_BEQ:   w_next_state = S_BRANCH;
          OP_J:     w_next_state = S_JUMP;
          default:  w_next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (r_op_q == OP_LW) begin
          w_next_state = S_MEM_RD;
        end else begin
          w_next_state = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          w_next_state = S_MEM_WB;
        end else begin
          w_next_state = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEM_WR;
        end
      end
      S_R_EXEC: w_next_state = S_R_WB;
      S_I_EXEC: w_next_state = S_I_WB;
      S_MEM_WB: w_next_state = S_FETCH;
      S_R_WB:   w_next_state = S_FETCH;
      S_I_WB:   w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;  // unused codes 12-15 recover
    endcase
  end

  // While rst is held the outputs show the FETCH decode even before the
  // first reset edge has moved the state register.
  always_comb begin
    if (rst) begin
      w_out_state = S_FETCH;
    end else begin
      w_out_state = r_state;
    end
  end

  // Moore output decode; only the FETCH write enables and illegal_op look
  // at inputs, and rst masks both.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUop       = ALU_ADD;
    illegal_op  = 1'b0;
    case (w_out_state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready & ~rst;
        PCWrite  = mem_ready & ~rst;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW,
          OP_SW, OP_BEQ, OP_J: illegal_op = 1'b0;
          default:             illegal_op = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_RTYPE;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (r_op_q == OP_SLTI) begin
          ALUop = ALU_SLT;
        end else begin
          ALUop = ALU_ADD;
        end
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: begin
        ALUop = ALU_ADD;
      end
    endcase
  end

  assign state_out = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUop;
  logic [3:0] state_out;
  logic       illegal_op;

  int errors = 0;
  int checks = 0;

  main_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .state_out(state_out), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    tick(); tick();
    // reset holds FETCH and masks the mem_ready-gated enables
    chk("rst_state", {4'd0, state_out}, 8'd0);
    chk("rst_irwrite", {7'd0, IRWrite}, 8'd0);
    chk("rst_pcwrite", {7'd0, PCWrite}, 8'd0);
    chk("rst_memread", {7'd0, MemRead}, 8'd1);
    chk("rst_alusrcb", {6'd0, ALUSrcB}, 8'd1);

    // R-type: 0,1,6,7,0
    rst = 1'b0; opcode = 6'b000000; #1;
    chk("r_fetch_irwrite", {7'd0, IRWrite}, 8'd1);
    chk("r_fetch_pcwrite", {7'd0, PCWrite}, 8'd1);
    tick();
    chk("r_s1", {4'd0, state_out}, 8'd1);
    chk("r_dec_alusrcb", {6'd0, ALUSrcB}, 8'd3);
    chk("r_dec_illegal", {7'd0, illegal_op}, 8'd0);
    tick();
    chk("r_s6", {4'd0, state_out}, 8'd6);
    chk("r_exec_aluop", {5'd0, ALUop}, 8'd0);
    chk("r_exec_regwrite", {7'd0, RegWrite}, 8'd0);
    chk("r_exec_alusrca", {7'd0, ALUSrcA}, 8'd1);
    tick();
    chk("r_s7", {4'd0, state_out}, 8'd7);
    chk("r_wb_regwrite", {7'd0, RegWrite}, 8'd1);
    chk("r_wb_regdst", {7'd0, RegDst}, 8'd1);
    tick();
    chk("r_s0", {4'd0, state_out}, 8'd0);
    chk("r_s0_regwrite", {7'd0, RegWrite}, 8'd0);

    // lw with two wait cycles in MEM_RD: 0,1,2,3,3,3,4,0
    opcode = 6'b000011;
    tick();
    chk("lw_s1", {4'd0, state_out}, 8'd1);
    tick();
    chk("lw_s2", {4'd0, state_out}, 8'd2);
    chk("lw_addr_alusrcb", {6'd0, ALUSrcB}, 8'd2);
    mem_ready = 1'b0;
    tick();
    chk("lw_s3a", {4'd0, state_out}, 8'd3);
    chk("lw_rd_iord", {7'd0, IorD}, 8'd1);
    chk("lw_rd_memread", {7'd0, MemRead}, 8'd1);
    tick();
    chk("lw_s3b", {4'd0, state_out}, 8'd3);
    tick();
    chk("lw_s3c", {4'd0, state_out}, 8'd3);
    chk("lw_rd_hold_memread", {7'd0, MemRead}, 8'd1);
    mem_ready = 1'b1;
    tick();
    chk("lw_s4", {4'd0, state_out}, 8'd4);
    chk("lw_wb_memtoreg", {7'd0, MemtoReg}, 8'd1);
    chk("lw_wb_regwrite", {7'd0, RegWrite}, 8'd1);
    chk("lw_wb_regdst", {7'd0, RegDst}, 8'd0);
    tick();
    chk("lw_s0", {4'd0, state_out}, 8'd0);

    // sw, then reset during the MemWrite wait
    opcode = 6'b000100;
    tick(); tick(); tick();
    chk("sw_s5", {4'd0, state_out}, 8'd5);
    chk("sw_memwrite", {7'd0, MemWrite}, 8'd1);
    mem_ready = 1'b0;
    tick();
    chk("sw_wait_s5", {4'd0, state_out}, 8'd5);
    chk("sw_wait_memwrite", {7'd0, MemWrite}, 8'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("swrst_state", {4'd0, state_out}, 8'd0);
    chk("swrst_memwrite", {7'd0, MemWrite}, 8'd0);
    chk("swrst_memread", {7'd0, MemRead}, 8'd1);
    chk("swrst_irwrite", {7'd0, IRWrite}, 8'd0);

    // FETCH waiting 3 cycles on mem_ready
    tick();
    chk("fw1_state", {4'd0, state_out}, 8'd0);
    chk("fw1_irwrite", {7'd0, IRWrite}, 8'd0);
    tick();
    chk("fw2_state", {4'd0, state_out}, 8'd0);
    chk("fw2_irwrite", {7'd0, IRWrite}, 8'd0);
    mem_ready = 1'b1; opcode = 6'b000010; #1;
    chk("fw_ready_irwrite", {7'd0, IRWrite}, 8'd1);

    // slti, with opcode switched to j during I_EXEC
    tick();
    chk("slti_s1", {4'd0, state_out}, 8'd1);
    tick();
    chk("slti_s10", {4'd0, state_out}, 8'd10);
    chk("slti_aluop", {5'd0, ALUop}, 8'd2);
    opcode = 6'b000110; #1;
    chk("slti_aluop_after_opchg", {5'd0, ALUop}, 8'd2);
    tick();
    chk("slti_s11", {4'd0, state_out}, 8'd11);
    chk("slti_wb_regwrite", {7'd0, RegWrite}, 8'd1);
    chk("slti_wb_regdst", {7'd0, RegDst}, 8'd0);
    tick();
    chk("slti_s0", {4'd0, state_out}, 8'd0);

    // addi
    opcode = 6'b000001;
    tick(); tick();
    chk("addi_s10", {4'd0, state_out}, 8'd10);
    chk("addi_aluop", {5'd0, ALUop}, 8'd3);
    tick();
    chk("addi_s11", {4'd0, state_out}, 8'd11);
    tick();

    // beq: 0,1,8,0
    opcode = 6'b000101;
    tick(); tick();
    chk("beq_s8", {4'd0, state_out}, 8'd8);
    chk("beq_aluop", {5'd0, ALUop}, 8'd1);
    chk("beq_pcwritecond", {7'd0, PCWriteCond}, 8'd1);
    chk("beq_pcsource", {6'd0, PCSource}, 8'd1);
    chk("beq_pcwrite", {7'd0, PCWrite}, 8'd0);
    tick();
    chk("beq_s0", {4'd0, state_out}, 8'd0);

    // j: 0,1,9,0
    opcode = 6'b000110;
    tick(); tick();
    chk("j_s9", {4'd0, state_out}, 8'd9);
    chk("j_pcwrite", {7'd0, PCWrite}, 8'd1);
    chk("j_pcsource", {6'd0, PCSource}, 8'd2);
    tick();
    chk("j_s0", {4'd0, state_out}, 8'd0);

    // illegal opcode: one-cycle pulse in DECODE, then FETCH
    opcode = 6'b111111;
    tick();
    chk("ill_s1", {4'd0, state_out}, 8'd1);
    chk("ill_pulse", {7'd0, illegal_op}, 8'd1);
    tick();
    chk("ill_s0", {4'd0, state_out}, 8'd0);
    chk("ill_clear", {7'd0, illegal_op}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
